// File: rtl/irq_source_if.sv
// GPU bus register port of the interrupt source: write/read strobes, register select and data.
// The bus initiator uses the master view and irq_source uses the slave view.
interface irq_source_if;
    logic        regwr;
    logic        regrd;
    logic        reg_sel;
    logic [31:0] gpu_din;
    logic [31:0] gpu_dout_out;
    logic        gpu_dout_oe;

    modport master (
        output regwr, regrd, reg_sel, gpu_din,
        input  gpu_dout_out, gpu_dout_oe
    );

    modport slave (
        input  regwr, regrd, reg_sel, gpu_din,
        output gpu_dout_out, gpu_dout_oe
    );
endinterface

// File: rtl/irq_source.sv
// Interrupt source: edge-detected peripheral events plus a prescaled timer, masked into pending
// latches, issuing one-cycle gpu_irq pulses and a level cpu_int. Supports NSRC <= 8, TMR_W <= 16.
module irq_source #(
    parameter int NSRC  = 5,
    parameter int TMR_W = 16
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [NSRC-1:0] ev_in,
    irq_source_if.slave     bus,
    output logic [NSRC-1:0] gpu_irq,
    output logic            cpu_int
);

    logic [NSRC-2:0]  ev_q;
    logic [NSRC-1:0]  enable_q, enable_d;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  irq_q;
    logic             cpu_int_q;
    logic [TMR_W-1:0] pre_q, pre_d, div_q, div_d;
    logic [TMR_W-1:0] pcnt_q, pcnt_d, dcnt_q, dcnt_d;

    logic             intctl_wr, timer_wr, run, tick;
    logic [NSRC-2:0]  edge_v;
    logic [NSRC-1:0]  acc, clr;
    logic [31:0]      intctl_rd, timer_rd;

    // The top event bit belongs to the timer slot and is not a peripheral line.
    logic unused_ev;
    assign unused_ev = ev_in[NSRC-1];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned
        // and no latch is inferred.
        pcnt_d    = pcnt_q;
        dcnt_d    = dcnt_q;
        pre_d     = pre_q;
        div_d     = div_q;
        intctl_rd = '0;
        timer_rd  = '0;

        intctl_wr = bus.regwr & ~bus.reg_sel;
        timer_wr  = bus.regwr &  bus.reg_sel;

        run  = (pre_q != '0) && (div_q != '0);
        tick = run && (pcnt_q == '0) && (dcnt_q == '0);

        // A timer write reloads both counters, restarting the period from the new values.
        if (timer_wr) begin
            pre_d  = bus.gpu_din[TMR_W-1:0];
            div_d  = bus.gpu_din[16 +: TMR_W];
            pcnt_d = bus.gpu_din[TMR_W-1:0];
            dcnt_d = bus.gpu_din[16 +: TMR_W];
        end else if (run) begin
            if (pcnt_q == '0) begin
                pcnt_d = pre_q;
                dcnt_d = (dcnt_q == '0) ? div_q : dcnt_q - TMR_W'(1);
            end else begin
                pcnt_d = pcnt_q - TMR_W'(1);
            end
        end

        edge_v = ev_in[NSRC-2:0] & ~ev_q;
        acc    = {tick, edge_v} & enable_q;
        clr    = intctl_wr ? bus.gpu_din[8 +: NSRC] : '0;

        // Set after clear: an accept in the same cycle as its clear keeps the pending bit.
        pending_d = (pending_q & ~clr) | acc;
        enable_d  = intctl_wr ? bus.gpu_din[NSRC-1:0] : enable_q;

        intctl_rd[NSRC-1:0]   = enable_q;
        intctl_rd[8 +: NSRC]  = pending_q;
        timer_rd[TMR_W-1:0]   = pre_q;
        timer_rd[16 +: TMR_W] = div_q;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the
        // values from before this edge.
        if (reset) begin
            ev_q      <= '1;
            enable_q  <= '0;
            pending_q <= '0;
            irq_q     <= '0;
            cpu_int_q <= 1'b0;
            pre_q     <= '0;
            div_q     <= '0;
            pcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            ev_q      <= ev_in[NSRC-2:0];
            enable_q  <= enable_d;
            pending_q <= pending_d;
            irq_q     <= acc;
            cpu_int_q <= |(pending_q & enable_q);
            pre_q     <= pre_d;
            div_q     <= div_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign gpu_irq          = irq_q;
    assign cpu_int          = cpu_int_q;
    assign bus.gpu_dout_oe  = bus.regrd;
    assign bus.gpu_dout_out = !bus.regrd ? 32'h0 : (bus.reg_sel ? timer_rd : intctl_rd);

endmodule
